// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Shared definitions for the asteroid-escape game sequencer:
//   - game_state_e  : state codes driven on game_flow_ctrl.game_state
//   - over_reason_e : reason codes driven on game_flow_ctrl.over_reason
//   - button index constants into the 5-bit btn bus
//   - max_int       : helper used to size the hold-seconds counter
// -----------------------------------------------------------------------------
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_OPENING   = 3'd1,
    ST_RUNNING   = 3'd2,
    ST_GAME_OVER = 3'd3,
    ST_LEVEL_UP  = 3'd4,
    ST_LIFE_LOST = 3'd5,
    ST_PAUSED    = 3'd6
  } game_state_e;

  typedef enum logic [1:0] {
    RSN_NONE      = 2'd0,
    RSN_COLLISION = 2'd1,
    RSN_TIMEOUT   = 2'd2,
    RSN_WIN       = 2'd3
  } over_reason_e;

  localparam int NUM_BTNS  = 5;
  localparam int START_BTN = 0;
  localparam int PAUSE_BTN = 1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_edge_det.sv
// -----------------------------------------------------------------------------
// btn_edge_det
// Per-bit rising-edge detector. Keeps a registered copy of the (already
// synchronised) button bus and flags bits that are high now but were low on
// the previous cycle. A held button therefore yields a single one-cycle pulse.
//
// Ports:
//   clk     in   clock
//   rst     in   asynchronous active-high reset (clears the registered copy)
//   btn_i   in   WIDTH  button levels
//   rise_o  out  WIDTH  one-cycle rising-edge pulses
// -----------------------------------------------------------------------------
module btn_edge_det #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] btn_i,
  output logic [WIDTH-1:0] rise_o
);

  logic [WIDTH-1:0] btn_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_q <= '0;
    end else begin
      btn_q <= btn_i;
    end
  end

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rise
      assign rise_o[gi] = btn_i[gi] & ~btn_q[gi];
    end
  endgenerate

endmodule

// File: rtl/game_flow_ctrl.sv
// -----------------------------------------------------------------------------
// game_flow_ctrl
// Top-level game sequencer: levels, lives, timed inter-level / life-lost
// holds, timed game-over hold, game-over reason and countdown timer control.
//
// Optional feature macro: GAME_PAUSE_EN
//   defined   -> PAUSED state and the pause-button edge are compiled in.
//   undefined -> btn[1] is ignored; state code 6 is treated as illegal.
//
// Ports:
//   game_clk            in   clock
//   rst                 in   asynchronous active-high reset
//   btn                 in   5  synchronised buttons (0 = start, 1 = pause)
//   sec_tick            in   one-cycle pulse per second
//   collision_detected  in   ship hit (level)
//   exit_reached        in   ship at exit (level)
//   timer_bcd           in   4*NUM_DIGITS countdown value, digit 0 in [3:0]
//   game_state          out  3  current state code
//   level               out  current level, 0-based
//   lives               out  remaining lives
//   timer_load          out  one-cycle reload pulse for the countdown
//   timer_run           out  countdown enable
//   over_reason         out  2  NONE/COLLISION/TIMEOUT/WIN
//   hold_secs           out  seconds elapsed in the current state
// All outputs are registered.
// -----------------------------------------------------------------------------
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int LEVELS        = 4,
  parameter int LIVES         = 3,
  parameter int INTER_SEC     = 2,
  parameter int OVER_HOLD_SEC = 8
) (
  input  logic                                                   game_clk,
  input  logic                                                   rst,
  input  logic [4:0]                                             btn,
  input  logic                                                   sec_tick,
  input  logic                                                   collision_detected,
  input  logic                                                   exit_reached,
  input  logic [4*NUM_DIGITS-1:0]                                timer_bcd,
  output logic [2:0]                                             game_state,
  output logic [$clog2(LEVELS)-1:0]                              level,
  output logic [$clog2(LIVES+1)-1:0]                             lives,
  output logic                                                   timer_load,
  output logic                                                   timer_run,
  output logic [1:0]                                             over_reason,
  output logic [$clog2(max_int(INTER_SEC, OVER_HOLD_SEC)+1)-1:0] hold_secs
);

  localparam int LW  = $clog2(LEVELS);
  localparam int LVW = $clog2(LIVES+1);
  localparam int HW  = $clog2(max_int(INTER_SEC, OVER_HOLD_SEC)+1);

  localparam logic [LW-1:0]  LEVEL_LAST = LW'(LEVELS-1);
  localparam logic [LW-1:0]  LEVEL_ONE  = LW'(1);
  localparam logic [LVW-1:0] LIVES_INIT = LVW'(LIVES);
  localparam logic [LVW-1:0] LIVES_ONE  = LVW'(1);
  localparam logic [HW-1:0]  INTER_CNT  = HW'(INTER_SEC);
  localparam logic [HW-1:0]  OVER_CNT   = HW'(OVER_HOLD_SEC);
  localparam logic [HW-1:0]  HOLD_MAX   = '1;

  // ---------------------------------------------------------------------------
  // Button edges
  // ---------------------------------------------------------------------------
  logic [NUM_BTNS-1:0] rise;
  logic                start_e;
  logic                pause_e;
  logic                unused_rise;

  btn_edge_det #(
    .WIDTH (NUM_BTNS)
  ) u_btn_edge (
    .clk    (game_clk),
    .rst    (rst),
    .btn_i  (btn),
    .rise_o (rise)
  );

  assign start_e = rise[START_BTN];

`ifdef GAME_PAUSE_EN
  assign pause_e     = rise[PAUSE_BTN];
  assign unused_rise = ^rise[NUM_BTNS-1:2];
`else
  assign pause_e     = 1'b0;
  assign unused_rise = ^{rise[NUM_BTNS-1:1], pause_e};
`endif

  // ---------------------------------------------------------------------------
  // Timeout: every BCD digit is zero
  // ---------------------------------------------------------------------------
  logic [NUM_DIGITS-1:0] digit_zero;
  logic                  timeout;

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign digit_zero[gi] = (timer_bcd[4*gi +: 4] == 4'h0);
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  game_state_e    state_q,      state_d;
  logic [LW-1:0]  level_q,      level_d;
  logic [LVW-1:0] lives_q,      lives_d;
  over_reason_e   reason_q,     reason_d;
  logic           timer_load_q, timer_load_d;
  logic           timer_run_q,  timer_run_d;
  logic [HW-1:0]  hold_q,       hold_d;

  // The timer has not yet been reloaded during the timer_load cycle, so its
  // stale zero value must not count as a timeout.
  assign timeout = (&digit_zero) & ~timer_load_q;

  always_ff @(posedge game_clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_OPENING;
      level_q      <= '0;
      lives_q      <= LIVES_INIT;
      reason_q     <= RSN_NONE;
      timer_load_q <= 1'b0;
      timer_run_q  <= 1'b0;
      hold_q       <= '0;
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      lives_q      <= lives_d;
      reason_q     <= reason_d;
      timer_load_q <= timer_load_d;
      timer_run_q  <= timer_run_d;
      hold_q       <= hold_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    lives_d  = lives_q;
    reason_d = reason_q;

    case (state_q)
      ST_IDLE: begin
        level_d  = '0;
        lives_d  = LIVES_INIT;
        reason_d = RSN_NONE;
        state_d  = ST_OPENING;
      end

      ST_OPENING: begin
        if (start_e) begin
          state_d = ST_RUNNING;
        end
      end

      ST_RUNNING: begin
        // Priority: collision, timeout, exit, pause.
        if (collision_detected) begin
          if (lives_q > LIVES_ONE) begin
            lives_d = lives_q - LIVES_ONE;
            state_d = ST_LIFE_LOST;
          end else begin
            lives_d  = '0;
            reason_d = RSN_COLLISION;
            state_d  = ST_GAME_OVER;
          end
        end else if (timeout) begin
          reason_d = RSN_TIMEOUT;
          state_d  = ST_GAME_OVER;
        end else if (exit_reached) begin
          if (level_q == LEVEL_LAST) begin
            reason_d = RSN_WIN;
            state_d  = ST_GAME_OVER;
          end else begin
            level_d = level_q + LEVEL_ONE;
            state_d = ST_LEVEL_UP;
          end
        end else if (pause_e) begin
          state_d = ST_PAUSED;
        end
      end

      ST_LEVEL_UP, ST_LIFE_LOST: begin
        if (hold_q >= INTER_CNT) begin
          state_d = ST_RUNNING;
        end
      end

      ST_GAME_OVER: begin
        if ((hold_q >= OVER_CNT) || start_e) begin
          state_d = ST_IDLE;
        end
      end

`ifdef GAME_PAUSE_EN
      ST_PAUSED: begin
        if (pause_e) begin
          state_d = ST_RUNNING;
        end
      end
`endif

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Reload only on entries that start a fresh countdown; returning from
    // PAUSED resumes the existing count.
    timer_load_d = (state_d == ST_RUNNING) &&
                   ((state_q == ST_OPENING) ||
                    (state_q == ST_LEVEL_UP) ||
                    (state_q == ST_LIFE_LOST));
    timer_run_d  = (state_d == ST_RUNNING);

    // A tick landing on the transition cycle belongs to neither state.
    if (state_d != state_q) begin
      hold_d = '0;
    end else if (sec_tick && (hold_q != HOLD_MAX)) begin
      hold_d = hold_q + 1'b1;
    end else begin
      hold_d = hold_q;
    end
  end

  assign game_state  = state_q;
  assign level       = level_q;
  assign lives       = lives_q;
  assign timer_load  = timer_load_q;
  assign timer_run   = timer_run_q;
  assign over_reason = reason_q;
  assign hold_secs   = hold_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// -----------------------------------------------------------------------------
// tb_game_flow_ctrl
// Self-checking bench for game_flow_ctrl with default parameters
// (LEVELS=4, LIVES=3, INTER_SEC=2, OVER_HOLD_SEC=8).
// Each record holds the inputs for one clock cycle and the outputs expected
// just after that edge. Expected records go through a scoreboard queue.
// -----------------------------------------------------------------------------
module tb_game_flow_ctrl;

  logic        game_clk;
  logic        rst;
  logic [4:0]  btn;
  logic        sec_tick;
  logic        collision_detected;
  logic        exit_reached;
  logic [15:0] timer_bcd;
  logic [2:0]  game_state;
  logic [1:0]  level;
  logic [1:0]  lives;
  logic        timer_load;
  logic        timer_run;
  logic [1:0]  over_reason;
  logic [3:0]  hold_secs;

  game_flow_ctrl dut (
    .game_clk           (game_clk),
    .rst                (rst),
    .btn                (btn),
    .sec_tick           (sec_tick),
    .collision_detected (collision_detected),
    .exit_reached       (exit_reached),
    .timer_bcd          (timer_bcd),
    .game_state         (game_state),
    .level              (level),
    .lives              (lives),
    .timer_load         (timer_load),
    .timer_run          (timer_run),
    .over_reason        (over_reason),
    .hold_secs          (hold_secs)
  );

  initial game_clk = 1'b0;
  always #5 game_clk = ~game_clk;

  typedef struct {
    logic [4:0]  btn;
    logic        tick;
    logic        col;
    logic        ex;
    logic [15:0] bcd;
    logic [2:0]  st;
    logic [1:0]  lvl;
    logic [1:0]  lv;
    logic        ld;
    logic        run;
    logic [1:0]  rsn;
    int          hold;   // -1: not checked
  } vec_t;

  localparam int NTBL = 24;
  vec_t tbl [NTBL];
  vec_t exp_q [$];
  int   n_vec = 0;
  int   n_bad = 0;

  // state codes
  localparam logic [2:0] S_IDLE = 3'd0, S_OPEN = 3'd1, S_RUN = 3'd2, S_GO = 3'd3,
                         S_LU = 3'd4, S_LL = 3'd5, S_PAUSE = 3'd6;
  localparam logic [15:0] BCD_NZ = 16'h1234;

  function automatic vec_t mk(input logic [4:0] b, input logic t, input logic c,
                              input logic x, input logic [15:0] bcd,
                              input logic [2:0] st, input logic [1:0] lvl,
                              input logic [1:0] lv, input logic ld, input logic run,
                              input logic [1:0] rsn, input int hold);
    vec_t v;
    v.btn = b; v.tick = t; v.col = c; v.ex = x; v.bcd = bcd;
    v.st = st; v.lvl = lvl; v.lv = lv; v.ld = ld; v.run = run; v.rsn = rsn;
    v.hold = hold;
    return v;
  endfunction

  task automatic check(input string tag, input vec_t e);
    logic bad;
    n_vec++;
    bad = (game_state !== e.st) || (level !== e.lvl) || (lives !== e.lv) ||
          (timer_load !== e.ld) || (timer_run !== e.run) || (over_reason !== e.rsn) ||
          ((e.hold >= 0) && (hold_secs !== e.hold[3:0]));
    if (bad) begin
      n_bad++;
      $display("FAIL %s: got st=%0d lvl=%0d lives=%0d load=%0b run=%0b rsn=%0d hold=%0d; want st=%0d lvl=%0d lives=%0d load=%0b run=%0b rsn=%0d hold=%0d",
               tag, game_state, level, lives, timer_load, timer_run, over_reason, hold_secs,
               e.st, e.lvl, e.lv, e.ld, e.run, e.rsn, e.hold);
    end else begin
      $display("ok   %s: st=%0d lvl=%0d lives=%0d load=%0b run=%0b rsn=%0d hold=%0d",
               tag, game_state, level, lives, timer_load, timer_run, over_reason, hold_secs);
    end
  endtask

  // One clock cycle: drive on negedge, push expectation, compare after posedge.
  task automatic apply(input string tag, input vec_t v);
    vec_t e;
    @(negedge game_clk);
    btn                = v.btn;
    sec_tick           = v.tick;
    collision_detected = v.col;
    exit_reached       = v.ex;
    timer_bcd          = v.bcd;
    exp_q.push_back(v);
    @(posedge game_clk);
    #1;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      check(tag, e);
    end
  endtask

  // Two ticks in a hold state, then the timed return to RUNNING with a reload.
  task automatic hold_then_run(input string tag, input logic [2:0] st,
                               input logic [1:0] lvl, input logic [1:0] lv);
    apply({tag, "_t1"}, mk(5'd0, 1, 0, 0, BCD_NZ, st, lvl, lv, 0, 0, 0, 1));
    apply({tag, "_t2"}, mk(5'd0, 1, 0, 0, BCD_NZ, st, lvl, lv, 0, 0, 0, 2));
    apply({tag, "_run"}, mk(5'd0, 0, 0, 0, BCD_NZ, S_RUN, lvl, lv, 1, 1, 0, 0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // start held for 10 cycles, then three collisions
    tbl[0]  = mk(5'd1, 0, 0, 0, BCD_NZ, S_RUN,  0, 3, 1, 1, 0, 0);
    for (int i = 1; i <= 9; i++)
      tbl[i] = mk(5'd1, 0, 0, 0, BCD_NZ, S_RUN, 0, 3, 0, 1, 0, 0);
    tbl[10] = mk(5'd0, 0, 1, 0, BCD_NZ, S_LL,   0, 2, 0, 0, 0, 0);
    tbl[11] = mk(5'd0, 1, 0, 0, BCD_NZ, S_LL,   0, 2, 0, 0, 0, 1);
    tbl[12] = mk(5'd0, 1, 0, 0, BCD_NZ, S_LL,   0, 2, 0, 0, 0, 2);
    tbl[13] = mk(5'd0, 0, 0, 0, BCD_NZ, S_RUN,  0, 2, 1, 1, 0, 0);
    tbl[14] = mk(5'd0, 0, 1, 0, BCD_NZ, S_LL,   0, 1, 0, 0, 0, 0);
    tbl[15] = mk(5'd0, 1, 0, 0, BCD_NZ, S_LL,   0, 1, 0, 0, 0, 1);
    tbl[16] = mk(5'd0, 1, 0, 0, BCD_NZ, S_LL,   0, 1, 0, 0, 0, 2);
    tbl[17] = mk(5'd0, 0, 0, 0, BCD_NZ, S_RUN,  0, 1, 1, 1, 0, 0);
    tbl[18] = mk(5'd0, 0, 1, 0, BCD_NZ, S_GO,   0, 0, 0, 0, 1, 0);
    tbl[19] = mk(5'd0, 1, 1, 0, BCD_NZ, S_GO,   0, 0, 0, 0, 1, 1);
    tbl[20] = mk(5'd1, 0, 0, 0, BCD_NZ, S_IDLE, 0, 0, 0, 0, 1, 0);
    tbl[21] = mk(5'd1, 0, 0, 0, BCD_NZ, S_OPEN, 0, 3, 0, 0, 0, 0);
    tbl[22] = mk(5'd0, 0, 0, 0, BCD_NZ, S_OPEN, 0, 3, 0, 0, 0, 0);
    tbl[23] = mk(5'd1, 0, 0, 0, BCD_NZ, S_RUN,  0, 3, 1, 1, 0, 0);

    btn = 5'd0; sec_tick = 0; collision_detected = 0; exit_reached = 0;
    timer_bcd = BCD_NZ;
    rst = 1'b1;
    #1;
    check("reset", mk(5'd0, 0, 0, 0, BCD_NZ, S_OPEN, 0, 3, 0, 0, 0, 0));
    #12;
    check("reset_held_clk", mk(5'd0, 0, 0, 0, BCD_NZ, S_OPEN, 0, 3, 0, 0, 0, 0));
    @(negedge game_clk);
    rst = 1'b0;

    for (int i = 0; i < NTBL; i++)
      apply($sformatf("tbl%0d", i), tbl[i]);

    // Timeout: zero during the load cycle ignored, one nonzero nibble not a timeout.
    apply("to_loadcyc", mk(5'd0, 0, 0, 0, 16'h0000, S_RUN, 0, 3, 0, 1, 0, 0));
    apply("to_hinib",   mk(5'd0, 0, 0, 0, 16'h1000, S_RUN, 0, 3, 0, 1, 0, 0));
    apply("to_zero",    mk(5'd0, 0, 0, 0, 16'h0000, S_GO,  0, 3, 0, 0, 2, 0));
    apply("to_start",   mk(5'd1, 0, 0, 0, 16'h0000, S_IDLE, 0, 3, 0, 0, 2, 0));
    apply("to_open",    mk(5'd0, 0, 0, 0, BCD_NZ,   S_OPEN, 0, 3, 0, 0, 0, 0));

    // Levels, simultaneous collision+exit, win, timed game-over hold.
    apply("lv_start",  mk(5'd1, 0, 0, 0, BCD_NZ, S_RUN, 0, 3, 1, 1, 0, 0));
    apply("lv_exit0",  mk(5'd0, 0, 0, 1, BCD_NZ, S_LU,  1, 3, 0, 0, 0, 0));
    hold_then_run("lu1", S_LU, 1, 3);
    apply("col_exit",  mk(5'd0, 1, 1, 1, BCD_NZ, S_LL,  1, 2, 0, 0, 0, 0));
    hold_then_run("ll1", S_LL, 1, 2);
    apply("lv_exit1",  mk(5'd0, 0, 0, 1, BCD_NZ, S_LU,  2, 2, 0, 0, 0, 0));
    hold_then_run("lu2", S_LU, 2, 2);
    apply("lv_exit2",  mk(5'd0, 0, 0, 1, BCD_NZ, S_LU,  3, 2, 0, 0, 0, 0));
    hold_then_run("lu3", S_LU, 3, 2);
    apply("win",       mk(5'd0, 0, 0, 1, BCD_NZ, S_GO,  3, 2, 0, 0, 3, 0));
    for (int k = 1; k <= 8; k++)
      apply($sformatf("go_t%0d", k), mk(5'd0, 1, 0, 0, BCD_NZ, S_GO, 3, 2, 0, 0, 3, k));
    apply("go_idle",   mk(5'd0, 0, 0, 0, BCD_NZ, S_IDLE, 3, 2, 0, 0, 3, 0));
    apply("go_open",   mk(5'd0, 0, 0, 0, BCD_NZ, S_OPEN, 0, 3, 0, 0, 0, 0));

    // Pause.
    apply("p_start",   mk(5'd1, 0, 0, 0, BCD_NZ, S_RUN, 0, 3, 1, 1, 0, 0));
`ifdef GAME_PAUSE_EN
    apply("p_enter",   mk(5'd2, 0, 0, 0, BCD_NZ, S_PAUSE, 0, 3, 0, 0, 0, 0));
    apply("p_col",     mk(5'd2, 1, 1, 1, 16'h0000, S_PAUSE, 0, 3, 0, 0, 0, 1));
    apply("p_rel",     mk(5'd0, 0, 0, 0, BCD_NZ, S_PAUSE, 0, 3, 0, 0, 0, 1));
    apply("p_resume",  mk(5'd2, 0, 0, 0, BCD_NZ, S_RUN,   0, 3, 0, 1, 0, 0));
`else
    apply("p_ignored", mk(5'd2, 0, 0, 0, BCD_NZ, S_RUN, 0, 3, 0, 1, 0, 0));
    apply("p_still",   mk(5'd0, 0, 0, 0, BCD_NZ, S_RUN, 0, 3, 0, 1, 0, 0));
`endif

    // Mid-game asynchronous reset, taken between clock edges.
    apply("pre_rst_col", mk(5'd0, 0, 1, 0, BCD_NZ, S_LL, 0, 2, 0, 0, 0, 0));
    @(posedge game_clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst", mk(5'd0, 0, 0, 0, BCD_NZ, S_OPEN, 0, 3, 0, 0, 0, 0));
    @(negedge game_clk);
    rst = 1'b0;
    apply("post_rst",  mk(5'd0, 0, 0, 0, BCD_NZ, S_OPEN, 0, 3, 0, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/game_flow_ctrl.md
# game_flow_ctrl

Parametrised top-level game sequencer for the asteroid-escape design. It supersedes the fixed four-state game FSM with multiple levels, a life counter, timed inter-level and life-lost holds, and an internally timed game-over hold. It adds a game-over reason code and an optional pause mode. It sits between the button/collision/exit sources and the countdown timer, renderer and score display, and owns the timer's load/run controls.

## Interface
Parameters:
- NUM_DIGITS, 4: BCD digits of the external countdown timer.
- LEVELS, 4: number of levels; the exit on level LEVELS-1 is a win.
- LIVES, 3: lives at game start; must be ≥1.
- INTER_SEC, 2: seconds held in LEVEL_UP / LIFE_LOST.
- OVER_HOLD_SEC, 8: seconds held in GAME_OVER.

Ports (clock and reset first):
- game_clk  in  1  single clock.
- rst  in  1  reset, **asynchronous, active-high**.
- btn  in  5  raw synchronised buttons; btn[0] = start, btn[1] = pause.
- sec_tick  in  1  one-cycle pulse per second.
- collision_detected  in  1  level; ship hit.
- exit_reached  in  1  level; ship at exit.
- timer_bcd  in  4*NUM_DIGITS  countdown value; digit 0 in [3:0].
- game_state  out  3  current state code.
- level  out  clog2(LEVELS)  current level, 0-based.
- lives  out  clog2(LIVES+1)  remaining lives.
- timer_load  out  1  one-cycle pulse; reload the countdown.
- timer_run  out  1  countdown enable.
- over_reason  out  2  0 NONE, 1 COLLISION, 2 TIMEOUT, 3 WIN.
- hold_secs  out  clog2(max(INTER_SEC,OVER_HOLD_SEC)+1)  elapsed seconds in the current hold state.

## Operation
- States and codes: IDLE 0, OPENING 1, RUNNING 2, GAME_OVER 3, LEVEL_UP 4, LIFE_LOST 5, PAUSED 6.
- Button inputs are rising-edge detected. start_e and pause_e are one cycle, derived from a registered copy of btn.
- IDLE: clear level to 0, lives to LIVES, over_reason to NONE. Next cycle go to OPENING.
- OPENING: on start_e, go to RUNNING and pulse timer_load. A held button produces no further edges.
- RUNNING: timer_run=1. The first matching event wins, evaluated in this order:
  1. collision: if lives>1, decrement lives and go to LIFE_LOST; otherwise set lives=0, over_reason=COLLISION, go to GAME_OVER.
  2. timeout (all NUM_DIGITS nibbles zero, ignored while timer_load=1): over_reason=TIMEOUT, go to GAME_OVER.
  3. exit: if level==LEVELS-1, over_reason=WIN, go to GAME_OVER; else increment level and go to LEVEL_UP.
  4. pause_e: go to PAUSED.
- LEVEL_UP / LIFE_LOST: timer_run=0. When hold_secs reaches INTER_SEC, pulse timer_load and go to RUNNING.
- GAME_OVER: timer_run=0; level, lives and over_reason frozen. When hold_secs reaches OVER_HOLD_SEC, or on start_e, go to IDLE.
- PAUSED: timer_run=0. Collision, exit and timeout are ignored. pause_e returns to RUNNING without reloading the timer.
- hold_secs clears on every state change and increments on sec_tick while the state is unchanged. A sec_tick in the transition cycle is not counted. The counter saturates at its maximum.
- Illegal state code: go to IDLE next cycle.

## Timing
- Reset values: game_state=OPENING (1), level=0, lives=LIVES, timer_load=0, timer_run=0, over_reason=0, hold_secs=0. The registered btn copy is also reset to 0.
- All outputs are registered. State responds one cycle after the qualifying input.
- timer_load is high for exactly the first cycle of each RUNNING entry from OPENING, LEVEL_UP or LIFE_LOST.
- Reset asserted mid-game returns to OPENING immediately (asynchronously), with no timer_load pulse.

## Configuration
- GAME_PAUSE_EN defined: the PAUSED state and the btn[1] edge logic are compiled in, as described above.
- GAME_PAUSE_EN undefined: PAUSED is unreachable and btn[1] is ignored. State code 6 is treated as illegal and goes to IDLE.

## Structure
- Shared package game_pkg holds the state codes, the over_reason codes, and the button index constants START_BTN=0 and PAUSE_BTN=1.
- Sub-module btn_edge_det (parametrised width, async active-high reset) produces the per-button rising-edge pulses.

## Test plan
- Reset, then btn[0] held for 10 cycles → exactly one transition to RUNNING, one timer_load pulse, lives=3, level=0.
- Three collisions, each after INTER_SEC=2 ticks in LIFE_LOST → lives 2, 1, then GAME_OVER with over_reason=1 and lives=0.
- timer_bcd=16'h0000 during the timer_load cycle → no timeout. The same value on the next cycle → GAME_OVER with over_reason=2.
- Exit on levels 0–2 → LEVEL_UP and level increments. Exit on level 3 → GAME_OVER with over_reason=3. After 8 sec_ticks → IDLE, then OPENING.
- Collision and exit in the same cycle with lives=3 → LIFE_LOST, lives=2, level unchanged.
- With GAME_PAUSE_EN: pause_e → PAUSED with timer_run=0, and a collision is ignored. A second pause_e → RUNNING with no timer_load pulse. Without the macro: pause_e leaves the state at RUNNING.
